// File: rtl/regress_pkg.sv
// -----------------------------------------------------------------------------
// regress_pkg
// Shared definitions for the least-squares regression job sequencer:
//   - 3-bit FSM state encodings and the state enum built from them
//   - bit positions inside the 2-bit error status
//   - default per-job sample count and wait-state timeout
// -----------------------------------------------------------------------------
package regress_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_KICK     = 3'd1;
    localparam logic [2:0] S_STREAM   = 3'd2;
    localparam logic [2:0] S_WAIT_ACC = 3'd3;
    localparam logic [2:0] S_INV      = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_KICK     = S_KICK,
        ST_STREAM   = S_STREAM,
        ST_WAIT_ACC = S_WAIT_ACC,
        ST_INV      = S_INV,
        ST_DONE     = S_DONE
    } state_t;

    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_TIMEOUT  = 1;

    localparam int DEFAULT_N       = 256;
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/valid_edge_latch.sv
// -----------------------------------------------------------------------------
// valid_edge_latch
// Turns a level "result valid" from an accumulator into a per-job event:
// only a fresh 0->1 transition counts, and it is remembered in a sticky flag
// until the next job clears it.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   valid  in   level valid from the accumulator
//   clr    in   synchronous clear of the sticky flag (asserted at job kick-off)
//   seen   out  a rising edge has been observed since the last clear,
//               including one arriving in the current cycle
// -----------------------------------------------------------------------------
module valid_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic clr,
    output logic seen
);

    logic prev_reg;
    logic flag_reg;
    logic rise;

    // The previous value is tracked every cycle, so a level that stayed high
    // from an earlier job never looks like a new edge.
    assign rise = valid & ~prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= 1'b0;
            flag_reg <= 1'b0;
        end else begin
            prev_reg <= valid;
            if (clr)
                flag_reg <= 1'b0;
            else if (rise)
                flag_reg <= 1'b1;
        end
    end

    // Including the live edge lets two edges in the same cycle advance the
    // sequencer without waiting for the flags to register.
    assign seen = flag_reg | rise;

endmodule

// File: rtl/regress_seq_ctrl.sv
// -----------------------------------------------------------------------------
// regress_seq_ctrl
// Sequences one least-squares regression job: kicks both moment accumulators,
// streams N (x, y) samples into them, waits for both results, then holds the
// 2x2 inverse unit's start until its result is valid. Reports completion,
// underrun / timeout status and a count of cleanly completed jobs.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   job_start               job request, only honoured while idle
//   busy, done              status: not idle / one-cycle end-of-job pulse
//   err[1:0]                [0] sample underrun, [1] timeout
//   smp_valid/x/y, smp_ready  upstream sample stream
//   acc_start, acc_x, acc_y   accumulator kick and sample data
//   xtx_valid, xty_valid      accumulator result valid levels
//   inv_start, inv_valid      inverse unit enable / result valid
//   job_cnt                   wrapping count of jobs finished without timeout
// -----------------------------------------------------------------------------
module regress_seq_ctrl
    import regress_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int JOB_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_start,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    input  logic             smp_valid,
    input  logic [15:0]      smp_x,
    input  logic [15:0]      smp_y,
    output logic             smp_ready,
    output logic             acc_start,
    output logic [15:0]      acc_x,
    output logic [15:0]      acc_y,
    input  logic             xtx_valid,
    input  logic             xty_valid,
    output logic             inv_start,
    input  logic             inv_valid,
    output logic [JOB_W-1:0] job_cnt
);

    localparam int CNT_W = $clog2(N) + 1;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    state_t             state_reg;
    logic [CNT_W-1:0]   stream_cnt_reg;
    logic [TMO_W-1:0]   tmo_cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               acc_start_reg;
    logic               inv_start_reg;
    logic [1:0]         err_reg;
    logic [JOB_W-1:0]   job_cnt_reg;

    logic [1:0]         acc_valid;
    logic [1:0]         acc_seen;
    logic               kick;
    logic               streaming;
    logic               tmo_hit;

    assign acc_valid = {xty_valid, xtx_valid};
    assign kick      = (state_reg == ST_KICK);
    assign streaming = (state_reg == ST_STREAM);
    assign tmo_hit   = (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));

    // One edge latch per accumulator; both are re-armed at kick-off.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            valid_edge_latch u_edge (
                .clk   (clk),
                .rst_n (rst_n),
                .valid (acc_valid[gi]),
                .clr   (kick),
                .seen  (acc_seen[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            stream_cnt_reg <= '0;
            tmo_cnt_reg    <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            acc_start_reg  <= 1'b0;
            inv_start_reg  <= 1'b0;
            err_reg        <= '0;
            job_cnt_reg    <= '0;
        end else begin
            done_reg      <= 1'b0;
            acc_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (job_start) begin
                        err_reg       <= '0;
                        acc_start_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_KICK;
                    end
                end
                ST_KICK: begin
                    stream_cnt_reg <= '0;
                    state_reg      <= ST_STREAM;
                end
                ST_STREAM: begin
                    // A missing sample is streamed as zero; only the status records it.
                    if (!smp_valid)
                        err_reg[ERR_UNDERRUN] <= 1'b1;
                    if (stream_cnt_reg == CNT_W'(N - 1)) begin
                        tmo_cnt_reg <= '0;
                        state_reg   <= ST_WAIT_ACC;
                    end else begin
                        stream_cnt_reg <= stream_cnt_reg + CNT_W'(1);
                    end
                end
                ST_WAIT_ACC: begin
                    if (&acc_seen) begin
                        tmo_cnt_reg   <= '0;
                        inv_start_reg <= 1'b1;
                        state_reg     <= ST_INV;
                    end else if (tmo_hit) begin
                        err_reg[ERR_TIMEOUT] <= 1'b1;
                        done_reg             <= 1'b1;
                        state_reg            <= ST_DONE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
                end
                ST_INV: begin
                    // inv_valid is checked first so a result on the last
                    // allowed cycle is not reported as a timeout.
                    if (inv_valid) begin
                        inv_start_reg <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else if (tmo_hit) begin
                        inv_start_reg        <= 1'b0;
                        err_reg[ERR_TIMEOUT] <= 1'b1;
                        done_reg             <= 1'b1;
                        state_reg            <= ST_DONE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!err_reg[ERR_TIMEOUT])
                        job_cnt_reg <= job_cnt_reg + JOB_W'(1);
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg      <= 1'b0;
                    inv_start_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign acc_start = acc_start_reg;
    assign inv_start = inv_start_reg;
    assign job_cnt   = job_cnt_reg;

    // Sample path is a straight pass-through while streaming so the
    // accumulators see each sample on the edge that consumes it.
    assign smp_ready = streaming;
    assign acc_x     = (streaming && smp_valid) ? smp_x : 16'd0;
    assign acc_y     = (streaming && smp_valid) ? smp_y : 16'd0;

endmodule

// File: tb/tb_regress_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regress_seq_ctrl
// Drives whole regression jobs into regress_seq_ctrl. Each job is described by
// when the accumulator valids rise, how long the inverse unit takes, which
// stream cycles lack a sample and any stray job_start pulses. The expected job
// timeline (done cycle, inverse window, error status) is derived from those
// parameters with plain cycle arithmetic and compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_regress_seq_ctrl;

    localparam int N       = 256;
    localparam int TIMEOUT = 64;
    localparam int JOB_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             job_start = 1'b0;
    logic             busy;
    logic             done;
    logic [1:0]       err;
    logic             smp_valid = 1'b0;
    logic [15:0]      smp_x = '0;
    logic [15:0]      smp_y = '0;
    logic             smp_ready;
    logic             acc_start;
    logic [15:0]      acc_x;
    logic [15:0]      acc_y;
    logic             xtx_valid = 1'b0;
    logic             xty_valid = 1'b0;
    logic             inv_start;
    logic             inv_valid = 1'b0;
    logic [JOB_W-1:0] job_cnt;

    int total = 0;
    int bad = 0;
    int exp_jobs = 0;
    bit under_mask [N];

    regress_seq_ctrl #(.N(N), .TIMEOUT(TIMEOUT), .JOB_W(JOB_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .job_start (job_start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .smp_valid (smp_valid),
        .smp_x     (smp_x),
        .smp_y     (smp_y),
        .smp_ready (smp_ready),
        .acc_start (acc_start),
        .acc_x     (acc_x),
        .acc_y     (acc_y),
        .xtx_valid (xtx_valid),
        .xty_valid (xty_valid),
        .inv_start (inv_start),
        .inv_valid (inv_valid),
        .job_cnt   (job_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic clear_mask;
        for (int j = 0; j < N; j++) under_mask[j] = 1'b0;
    endtask

    // One job. Cycle 0 is the idle cycle in which job_start is presented.
    // kx/ky: accumulator valid rises kx/ky cycles after the last sample (-1: never)
    // m:     inverse valid m cycles after inv_start first seen high (-1: never)
    // drop:  cycle at which a valid left high by the previous job falls
    task automatic run_job(input string name, input int kx, input int ky, input int m,
                           input int drop, input bit ramp_data,
                           input bit pulse_stream, input bit pulse_inv);
        int w0, rx, ry, g, inv_entry, d, ps, pi, run;
        int tl_bad, tl_first, sd_bad, sd_first, done_seen;
        bit to, any_under, stale_x, stale_y, sv, in_stream;
        logic [15:0] ex_x, ex_y;
        logic [1:0] err_at_done, exp_err;

        // Expected timeline: job_start(0), kick(1), N stream cycles, wait, inverse, done.
        w0 = N + 2;
        rx = (kx < 0) ? -1 : N + 1 + kx;
        ry = (ky < 0) ? -1 : N + 1 + ky;
        any_under = 1'b0;
        for (int j = 0; j < N; j++) if (under_mask[j]) any_under = 1'b1;
        if (rx >= 0 && ry >= 0) begin
            g = (rx > ry) ? rx : ry;
            if (g < w0) g = w0;
        end else begin
            g = -1;
        end
        if (g >= 0 && (g - w0) < TIMEOUT) begin
            inv_entry = g + 1;
            if (m >= 0 && m < TIMEOUT) begin
                d  = inv_entry + m + 1;
                to = 1'b0;
            end else begin
                d  = inv_entry + TIMEOUT;
                to = 1'b1;
            end
        end else begin
            inv_entry = -1;
            d  = w0 + TIMEOUT;
            to = 1'b1;
        end
        exp_err = {to, any_under};
        ps = pulse_stream ? 2 + N / 3 : -1;
        pi = (pulse_inv && inv_entry >= 0 && inv_entry + 1 < d - 1) ? inv_entry + 1 : -1;

        stale_x = (xtx_valid === 1'b1);
        stale_y = (xty_valid === 1'b1);
        run = 0;
        tl_bad = 0; tl_first = -1;
        sd_bad = 0; sd_first = -1;
        done_seen = 0;
        err_at_done = 2'bxx;

        for (int c = 0; c <= d; c++) begin
            @(posedge clk);
            #1;
            in_stream = (c >= 2) && (c <= N + 1);
            job_start = (c == 0) || (c == ps) || (c == pi);
            sv = in_stream ? !under_mask[in_stream ? c - 2 : 0] : 1'($urandom_range(0, 1));
            smp_valid = sv;
            if (ramp_data && in_stream) begin
                smp_x = 16'(c - 2);
                smp_y = 16'(2 * (c - 2));
            end else begin
                smp_x = 16'($urandom);
                smp_y = 16'($urandom);
            end
            xtx_valid = (stale_x && c < drop) || (rx >= 0 && c >= rx);
            xty_valid = (stale_y && c < drop) || (ry >= 0 && c >= ry);
            run = (inv_start === 1'b1) ? run + 1 : 0;
            inv_valid = (m >= 0) && (inv_start === 1'b1) && (run > m);

            @(negedge clk);
            if (c == 0) begin
                total++;
                if (job_cnt !== JOB_W'(exp_jobs)) begin
                    bad++;
                    $display("FAIL %s job_cnt_start: got %0d required %0d", name, job_cnt, JOB_W'(exp_jobs));
                end
            end
            if (busy !== (c >= 1) || done !== (c == d) || acc_start !== (c == 1) ||
                smp_ready !== in_stream ||
                inv_start !== (inv_entry >= 0 && c >= inv_entry && c < d)) begin
                tl_bad++;
                if (tl_first < 0) tl_first = c;
            end
            ex_x = (in_stream && sv) ? smp_x : 16'd0;
            ex_y = (in_stream && sv) ? smp_y : 16'd0;
            if (acc_x !== ex_x || acc_y !== ex_y) begin
                sd_bad++;
                if (sd_first < 0) sd_first = c;
            end
            if (done === 1'b1) begin
                done_seen++;
                err_at_done = err;
            end
        end
        job_start = 1'b0;

        total++;
        if (tl_bad != 0) begin
            bad++;
            $display("FAIL %s timeline: got %0d wrong cycles (first at cycle %0d) required 0, done expected at cycle %0d",
                     name, tl_bad, tl_first, d);
        end
        total++;
        if (sd_bad != 0) begin
            bad++;
            $display("FAIL %s stream_data: got %0d wrong cycles (first at cycle %0d) required 0", name, sd_bad, sd_first);
        end
        total++;
        if (done_seen != 1) begin
            bad++;
            $display("FAIL %s done_pulses: got %0d required 1", name, done_seen);
        end
        total++;
        if (err_at_done !== exp_err) begin
            bad++;
            $display("FAIL %s err_at_done: got %b required %b", name, err_at_done, exp_err);
        end
        if (!to) exp_jobs++;
        $display("job %s: done expected at cycle %0d, err=%b, jobs completed=%0d", name, d, err_at_done, exp_jobs);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        job_start = 1'b1;
        smp_valid = 1'b1;
        smp_x = 16'hA5A5;
        smp_y = 16'h5A5A;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, err, smp_ready, acc_start, inv_start, job_cnt, acc_x, acc_y} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {busy, done, err, smp_ready, acc_start, inv_start, job_cnt, acc_x, acc_y});
        end
        job_start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || smp_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: got busy=%b smp_ready=%b required 0 0", busy, smp_ready);
        end
        $display("job reset: outputs checked during and after reset");
    endtask

    task automatic test_clean;
        clear_mask();
        run_job("clean", 2, 2, 6, 2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_acc_timeout;
        clear_mask();
        run_job("acc_timeout", 2, -1, 6, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_underrun;
        clear_mask();
        under_mask[10]  = 1'b1;
        under_mask[200] = 1'b1;
        run_job("underrun", int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                int'($urandom_range(1, 10)), 2, 1'b0, 1'b0, 1'b0);
    endtask

    // Both valids are still high from the previous job; they only fall well
    // into the wait and rise again later, so the inverse must not start early.
    task automatic test_stale;
        clear_mask();
        run_job("stale_valid", 9, 12, 5, N + 7, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_inv_timeout;
        clear_mask();
        run_job("inv_last_cycle", 3, 1, TIMEOUT - 1, 2, 1'b0, 1'b0, 1'b0);
        run_job("inv_timeout", 1, 1, -1, 2, 1'b0, 1'b0, 1'b0);
        run_job("acc_same_cycle", 4, 4, 2, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        clear_mask();
        run_job("ignored_starts", 2, 3, 6, 2, 1'b0, 1'b1, 1'b1);
        run_job("back_to_back", 2, 2, 4, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        clear_mask();
        for (int c = 0; c <= N / 2 - 26; c++) begin
            @(posedge clk);
            #1;
            job_start = (c == 0);
            smp_valid = 1'b1;
            smp_x = 16'($urandom) | 16'h0001;
            smp_y = 16'($urandom) | 16'h0001;
            if (c == 101) begin
                @(negedge clk);
                total++;
                if (smp_ready !== 1'b1 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL mid_streaming: got smp_ready=%b busy=%b required 1 1", smp_ready, busy);
                end
            end
        end
        // Now inside stream cycle 100; reset acts without waiting for a clock edge.
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err, smp_ready, acc_start, inv_start, job_cnt, acc_x, acc_y} !== '0) begin
            bad++;
            $display("FAIL reset_async: got %h required 0",
                     {busy, done, err, smp_ready, acc_start, inv_start, job_cnt, acc_x, acc_y});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_jobs = 0;
        $display("job reset_mid: reset asserted at stream cycle 100");
        run_job("after_reset", 2, 2, 6, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        int kx, ky, m;
        for (int r = 0; r < 4; r++) begin
            clear_mask();
            for (int u = 0; u < int'($urandom_range(0, 3)); u++)
                under_mask[$urandom_range(0, N - 1)] = 1'b1;
            kx = int'($urandom_range(1, 8));
            ky = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 8));
            m  = ($urandom_range(0, 3) == 0) ? 70 : int'($urandom_range(1, 20));
            run_job($sformatf("random_%0d", r), kx, ky, m, 2, 1'b0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_acc_timeout();
        test_underrun();
        test_stale();
        test_inv_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
